// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the data memory: port 0 (load/store unit) normally wins, port 1 (debug/DMA) is forced through after MAX_WAIT refusals.
// Optional round-robin contention rule enabled by defining DMEM_ARB_RR_EN.
module dmem_arbiter #(
  parameter int         MAX_WAIT = 4,
  parameter logic [2:0] IDLE_OP  = 3'b100
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [2:0]  m0_op,
  input  logic [10:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_rvalid,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [2:0]  m1_op,
  input  logic [10:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_rvalid,
  output logic [31:0] rdata_o,
  output logic        mem_stall,
  output logic [2:0]  mem_op_code,
  output logic [10:0] mem_rwaddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic       resp_pend;
  logic       resp_owner;
  logic [3:0] wait_cnt;
  logic       contended;
  logic       force1;
  logic       pick1;
  logic       grant0;
  logic       grant1;
  logic       win_read;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;
`endif

  // Grants are gated by nrst so the memory sees no access while reset is held.
  always_comb begin
    contended = m0_valid & m1_valid;
    force1    = (wait_cnt == 4'(MAX_WAIT));
`ifdef DMEM_ARB_RR_EN
    pick1     = contended ? (force1 | rr_ptr) : m1_valid;
`else
    pick1     = contended ? force1 : m1_valid;
`endif
    grant1    = nrst & m1_valid & pick1;
    grant0    = nrst & m0_valid & ~pick1;
  end

  assign m0_ready = grant0;
  assign m1_ready = grant1;

  always_comb begin
    mem_stall   = 1'b1;
    mem_op_code = IDLE_OP;
    mem_rwaddr  = '0;
    mem_wdata   = '0;
    win_read    = 1'b0;
    if (grant1) begin
      mem_stall   = 1'b0;
      mem_op_code = m1_op;
      mem_rwaddr  = m1_addr;
      mem_wdata   = m1_wdata;
      win_read    = m1_op[2];
    end else if (grant0) begin
      mem_stall   = 1'b0;
      mem_op_code = m0_op;
      mem_rwaddr  = m0_addr;
      mem_wdata   = m0_wdata;
      win_read    = m0_op[2];
    end
  end

  // Memory read data arrives one cycle after the access; remember who asked for it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      resp_pend  <= 1'b0;
      resp_owner <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      resp_pend <= win_read;
      if (win_read)
        resp_owner <= grant1;
      if (m1_valid & ~grant1) begin
        if (wait_cnt != 4'(MAX_WAIT))
          wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Only contended grants move the preference, towards the loser.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      rr_ptr <= 1'b0;
    else if (contended)
      rr_ptr <= ~grant1;
  end
`endif

  assign m0_rvalid = resp_pend & ~resp_owner;
  assign m1_rvalid = resp_pend & resp_owner;
  assign rdata_o   = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the data-memory block (op_code / rwaddr / wdata / rdata / stall interface).
- Port 0 is the core load/store unit; port 1 is the debug/DMA port.
- Grants at most one access per cycle and drives the memory side combinationally from the winner.
- Tracks the one-cycle memory read latency, so read data returns to the owning requester with an rvalid strobe.

Parameters:
- MAX_WAIT, 4: cycles port 1 may be refused while requesting before it is forced to win; range 1..15.
- IDLE_OP, 3'b100: op_code driven to memory when no grant. Bit 2 = 1 means no write.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- m0_valid  in  1  port 0 request
- m0_ready  out  1  port 0 grant; transfer occurs when valid & ready
- m0_op  in  3  port 0 op_code (mem.vh encoding; bit 2 = 0 is store)
- m0_addr  in  11  port 0 byte address
- m0_wdata  in  32  port 0 store data
- m0_rvalid  out  1  port 0 read data valid
- m1_valid, m1_ready, m1_op, m1_addr, m1_wdata, m1_rvalid: same as port 0, for port 1
- rdata_o  out  32  read data, shared by both ports; qualified by mX_rvalid
- mem_stall  out  1  to memory stall; 1 = no access this cycle
- mem_op_code  out  3  to memory op_code
- mem_rwaddr  out  11  to memory rwaddr
- mem_wdata  out  32  to memory wdata
- mem_rdata  in  32  from memory rdata; valid one cycle after the access

Behaviour:
- Clock and reset: one clock domain, clk. nrst is asynchronous, active-low.
- Reset values: resp_pend=0, resp_owner=0, wait_cnt=0, rr_ptr=0.
  - Outputs under reset: m0_rvalid=0, m1_rvalid=0, mem_stall=1.
- Grant is combinational, in the same cycle as the request:
  - Only one valid: that port wins.
  - Both valid: port 1 wins if wait_cnt==MAX_WAIT; otherwise the priority rule decides. Default rule: port 0 wins.
  - m0_ready and m1_ready are one-hot or zero, and each is never asserted without the matching valid.
- Memory side, with a grant: mem_op_code, mem_rwaddr and mem_wdata come from the winner; mem_stall=0.
- Memory side, no grant: mem_stall=1, mem_op_code=IDLE_OP, mem_rwaddr=0, mem_wdata=0.
- Masters hold op, addr and wdata stable while valid & !ready. The arbiter does not check this.
- Response tracking:
  - On a granted read (op[2]==1), resp_pend<=1 and resp_owner<=winner.
  - Otherwise resp_pend<=0.
  - m0_rvalid = resp_pend & (resp_owner==0); m1_rvalid = resp_pend & (resp_owner==1).
  - rdata_o = mem_rdata, unregistered.
  - Latency: read data is valid exactly 1 cycle after the transfer cycle.
  - A stored value is visible to a read issued in a later cycle, from any port.
- Back-to-back transfers are allowed every cycle. Reads to different ports may interleave; each rvalid follows its own transfer by exactly 1 cycle.
- Starvation counter wait_cnt:
  - Increments when m1_valid & !m1_ready, saturating at MAX_WAIT.
  - Clears to 0 when m1 transfers or m1_valid==0.
- Reset mid-operation: a pending response is dropped and no rvalid is issued after reset release. Masters must re-issue.
- No internal request queue: refused requests are the master's responsibility to hold.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - The contention rule becomes round-robin.
  - rr_ptr holds the preferred port. On any contended grant, rr_ptr <= ~winner.
  - Uncontended grants leave rr_ptr unchanged.
  - The MAX_WAIT override still applies first.
- Not defined: fixed priority, port 0 wins. rr_ptr is not implemented.

Test Plan:
- Reset: nrst=0 with both valids high -> mem_stall=1, m0_rvalid=m1_rvalid=0. After release, resp_pend is clear and no spurious rvalid appears.
- Single port 0 write then read:
  - Cycle 1: m0 StoreWord, addr 0x010, data 0xDEADBEEF -> m0_ready=1, mem_stall=0, no rvalid in cycle 2.
  - Cycle 3: m0 LoadWord, addr 0x010 -> cycle 4 m0_rvalid=1, rdata_o=0xDEADBEEF, m1_rvalid=0.
- Contention, fixed priority: both ports read every cycle, MAX_WAIT=4 -> m0 granted 4 cycles, m1 granted on cycle 5, wait_cnt back to 0, pattern repeats. Each rvalid goes to the correct port one cycle after its grant.
- Interleave: m0 reads 0x400 (mem2 bank), then m1 reads 0x004 (mem1 bank) in the next cycle -> m0_rvalid then m1_rvalid in consecutive cycles, each with correct data.
- DMEM_ARB_RR_EN: both ports continuously valid -> grants alternate 0,1,0,1 starting with port 0 after reset. Uncontended m1 grants do not move rr_ptr.
- Reset mid-read: m1 read granted, nrst pulsed low before the next edge -> m1_rvalid never asserts.
